// File: rtl/sram_rr_nport.sv
// Single-bank synchronous SRAM shared by NUM_CH requesters via round-robin arbitration.
// One op per cycle, registered read-before-write response; requests are held off during a clear sweep.
module sram_rr_nport #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 2,
  parameter int INIT_CLEAR = 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [NUM_CH-1:0]            i_req_valid,
  output logic [NUM_CH-1:0]            o_req_ready,
  input  logic [NUM_CH-1:0]            i_req_we,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] i_req_addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0] i_req_wdata,
  input  logic [NUM_CH*(DATA_WIDTH/8)-1:0] i_req_be,
  input  logic                         i_clear,
  output logic [NUM_CH-1:0]            o_rsp_valid,
  output logic [DATA_WIDTH-1:0]        o_rsp_rdata,
  output logic                         o_busy
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int BE_W  = DATA_WIDTH/8;
  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

  state_t                  state, state_nxt;
  logic                    init_pend;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic [PTR_W-1:0]        ptr;

  logic [ADDR_WIDTH-1:0]   req_addr_a  [NUM_CH];
  logic [DATA_WIDTH-1:0]   req_wdata_a [NUM_CH];
  logic [BE_W-1:0]         req_be_a    [NUM_CH];

  logic [PTR_W-1:0]        gnt_idx;
  logic [PTR_W-1:0]        cand;
  int                      arb_idx;
  logic                    found;
  logic                    can_grant;
  logic                    accept;

  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [BE_W-1:0]         mem_be;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      req_addr_a[k]  = i_req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
      req_wdata_a[k] = i_req_wdata[k*DATA_WIDTH +: DATA_WIDTH];
      req_be_a[k]    = i_req_be[k*BE_W +: BE_W];
    end
  end

  // Search starts one past the last granted channel, giving rotating priority.
  always_comb begin
    gnt_idx = ptr;
    cand    = ptr;
    arb_idx = 0;
    found   = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      arb_idx = (int'(ptr) + i) % NUM_CH;
      cand    = PTR_W'(arb_idx);
      if (!found && i_req_valid[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // init_pend keeps the first post-reset cycle from granting before the sweep starts.
  assign can_grant   = i_rst_n && (state == ST_IDLE) && !init_pend;
  assign accept      = can_grant && found;
  assign o_req_ready = accept ? (NUM_CH'(1) << gnt_idx) : '0;
  assign o_busy      = (state == ST_CLEAR);

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = req_addr_a[gnt_idx];
    mem_wdata = req_wdata_a[gnt_idx];
    mem_be    = req_be_a[gnt_idx];
    if (state == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_addr  = clr_cnt;
      mem_wdata = '0;
      mem_be    = '1;
    end else if (accept && i_req_we[gnt_idx]) begin
      mem_we    = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (mem_be[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (init_pend || i_clear) state_nxt = ST_CLEAR;
      ST_CLEAR: if (&clr_cnt)             state_nxt = ST_IDLE;
      default:                            state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      init_pend <= (INIT_CLEAR != 0);
      clr_cnt   <= '0;
      ptr       <= PTR_W'(NUM_CH-1);
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && state_nxt == ST_CLEAR) init_pend <= 1'b0;
      if (state == ST_CLEAR) clr_cnt <= clr_cnt + 1'b1;
      if (accept) ptr <= gnt_idx;
    end
  end

  // Response captures the word before this edge's write lands.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rsp_valid <= '0;
      o_rsp_rdata <= '0;
    end else begin
      o_rsp_valid <= o_req_ready;
      if (accept) o_rsp_rdata <= mem[req_addr_a[gnt_idx]];
    end
  end

endmodule
